// File: rtl/seg_pkg.sv
// Segment codes and hex decode shared by the 7-segment display blocks.
// Bit order is {dp,g,f,e,d,c,b,a}, all active-high.
package seg_pkg;

  localparam int SEG_DP = 7;
  localparam int SEG_A  = 0;

  localparam logic [7:0] SEG_OFF = 8'h00;

  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

  function automatic logic [6:0] hex2seg(input logic [3:0] hex);
    logic [6:0] s;
    s = SEG_HEX_0;
    case (hex)
      4'h0: s = SEG_HEX_0;
      4'h1: s = SEG_HEX_1;
      4'h2: s = SEG_HEX_2;
      4'h3: s = SEG_HEX_3;
      4'h4: s = SEG_HEX_4;
      4'h5: s = SEG_HEX_5;
      4'h6: s = SEG_HEX_6;
      4'h7: s = SEG_HEX_7;
      4'h8: s = SEG_HEX_8;
      4'h9: s = SEG_HEX_9;
      4'hA: s = SEG_HEX_A;
      4'hB: s = SEG_HEX_B;
      4'hC: s = SEG_HEX_C;
      4'hD: s = SEG_HEX_D;
      4'hE: s = SEG_HEX_E;
      default: s = SEG_HEX_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to {g..a} segment pattern.
// Zero latency, no handshake.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex2seg(hex);

endmodule

// File: rtl/seg_scan_4dig.sv
// 4-digit multiplexed 7-segment scanner; registered outputs, 1 cycle after (div_cnt, idx).
// One-entry pending buffer, committed only at frame boundaries; in_ready low while it is full.
// Build option SEG_LEADING_ZERO_BLANK_EN suppresses leading-zero segments on digits 3..1.
module seg_scan_4dig
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16,
  parameter int DIV_W     = 17
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [3:0]  in_dp,
  output logic [7:0]  seg,
  output logic [3:0]  digit,
  output logic        frame_tick
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic [15:0]      disp_data;
  logic [3:0]       disp_dp;
  logic             pend_full;
  logic [15:0]      pend_data;
  logic [3:0]       pend_dp;

  logic       slot_end;
  logic       fb;
  logic       accept;
  logic       in_blank;
  logic       lead_zero;
  logic [3:0] cur_nib;
  logic [6:0] dec_seg;

  assign slot_end = (div_cnt == DIV_LAST);
  assign fb       = slot_end && (idx == 2'd3);
  assign in_ready = ~pend_full;
  assign accept   = in_valid & ~pend_full;

  generate
    if (BLANK_CYC == 0) begin : g_noblank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (div_cnt < DIV_W'(BLANK_CYC));
    end
  endgenerate

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      div_cnt <= '0;
      idx     <= 2'd0;
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
      if (slot_end) idx <= idx + 2'd1;
    end
  end

  // Commit needs pend_full from before this edge, so a same-cycle accept waits a frame.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pend_full <= 1'b0;
      pend_data <= 16'h0;
      pend_dp   <= 4'h0;
      disp_data <= 16'h0;
      disp_dp   <= 4'h0;
    end else begin
      if (fb && pend_full) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
        pend_full <= 1'b0;
      end else if (accept) begin
        pend_data <= in_data;
        pend_dp   <= in_dp;
        pend_full <= 1'b1;
      end
    end
  end

  always_comb begin
    cur_nib = disp_data[3:0];
    case (idx)
      2'd1:    cur_nib = disp_data[7:4];
      2'd2:    cur_nib = disp_data[11:8];
      2'd3:    cur_nib = disp_data[15:12];
      default: cur_nib = disp_data[3:0];
    endcase
  end

  seg_hex_decode u_dec (
    .hex (cur_nib),
    .seg (dec_seg)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  always_comb begin
    lead_zero = 1'b0;
    case (idx)
      2'd3:    lead_zero = (disp_data[15:12] == 4'h0);
      2'd2:    lead_zero = (disp_data[15:8] == 8'h0);
      2'd1:    lead_zero = (disp_data[15:4] == 12'h0);
      default: lead_zero = 1'b0;
    endcase
  end
`else
  assign lead_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      seg        <= SEG_OFF;
      digit      <= 4'h0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= fb;
      if (in_blank) begin
        seg   <= SEG_OFF;
        digit <= 4'h0;
      end else begin
        digit               <= 4'b0001 << idx;
        seg[SEG_DP]         <= disp_dp[idx];
        seg[SEG_DP-1:SEG_A] <= lead_zero ? 7'h00 : dec_seg;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_4dig.sv
// Scoreboard bench for seg_scan_4dig: a cycle-count model predicts every output cycle.
module tb_seg_scan_4dig;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int DIV_W     = 3;
  localparam int FRAME     = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic [3:0]  in_dp = 4'h0;
  logic        in_ready;
  logic [7:0]  seg;
  logic [3:0]  digit;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_4dig #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .DIV_W     (DIV_W)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dp      (in_dp),
    .seg        (seg),
    .digit      (digit),
    .frame_tick (frame_tick)
  );

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] digit;
    logic       tick;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: position in the scan follows from the cycle count since reset.
  initial begin
    logic [6:0]  hex_tab [16];
    int unsigned k;
    logic [15:0] m_disp, m_pdata;
    logic [3:0]  m_dp, m_pdp;
    logic        m_pend;
    exp_t        e;
    int          slot, pos;
    bit          fb, acc, com;
    hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    k = 0; m_disp = 0; m_dp = 0; m_pend = 0; m_pdata = 0; m_pdp = 0;
    forever begin
      @(posedge clk or negedge rstb);
      if (!rstb) begin
        k = 0; m_disp = 0; m_dp = 0; m_pend = 0;
        exp_q.delete();
      end else begin
        slot = (k / SCAN_DIV) % 4;
        pos  = k % SCAN_DIV;
        fb   = ((k % FRAME) == FRAME - 1);
        e.tick = fb;
        if (pos < BLANK_CYC) begin
          e.seg = 8'h00;
          e.digit = 4'h0;
        end else begin
          e.digit = 4'(1 << slot);
          e.seg = {m_dp[slot], hex_tab[4'(m_disp >> (4 * slot))]};
`ifdef SEG_LEADING_ZERO_BLANK_EN
          if (slot > 0 && (m_disp >> (4 * slot)) == 16'h0) e.seg[6:0] = 7'h00;
`endif
        end
        acc = in_valid && !m_pend;
        com = fb && m_pend;
        if (com) begin
          m_disp = m_pdata; m_dp = m_pdp; m_pend = 1'b0;
        end
        if (acc) begin
          m_pdata = in_data; m_pdp = in_dp; m_pend = 1'b1;
        end
        e.rdy = !m_pend;
        exp_q.push_back(e);
        k++;
      end
    end
  end

  // Monitor: every output cycle is popped and compared; reset values checked while held.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rstb) begin
        checks++;
        if ({seg, digit, frame_tick, in_ready} !== {8'h00, 4'h0, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL rst_hold got seg=%h digit=%b tick=%b rdy=%b required 00 0000 0 1",
                   seg, digit, frame_tick, in_ready);
        end
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({seg, digit, frame_tick, in_ready} !== e) begin
          errors++;
          $display("FAIL scan t=%0t got seg=%h digit=%b tick=%b rdy=%b required seg=%h digit=%b tick=%b rdy=%b",
                   $time, seg, digit, frame_tick, in_ready, e.seg, e.digit, e.tick, e.rdy);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, expv);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic [3:0] dp);
    bit done;
    done = 0;
    in_data = d;
    in_dp = dp;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        done = 1;
      end
    end
    if (!done) begin
      in_valid = 1'b0;
      check("send_timeout", 32'd0, 32'd1);
    end
  endtask

  // Returns at the negedge where frame_tick is high.
  task automatic wait_tick();
    bit seen;
    seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (frame_tick) seen = 1;
    end
    if (!seen) check("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic skip_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_dig [4];
    logic [7:0] exp_seg [4];
    int gap;
    exp_dig = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_seg = '{8'h71, 8'h77, 8'hDB, 8'h06};

    // Reset asserted mid-slot with a pending value held
    repeat (2) @(negedge clk);
    #2 rstb = 1'b1;
    send(16'hBEEF, 4'hF);
    repeat (3) @(posedge clk);
    #3 rstb = 1'b0;
    #1;
    check("rst_seg", {24'h0, seg}, 32'h0);
    check("rst_digit", {28'h0, digit}, 32'h0);
    check("rst_ready", {31'h0, in_ready}, 32'h1);
    check("rst_tick", {31'h0, frame_tick}, 32'h0);
    @(negedge clk);
    #2 rstb = 1'b1;

    // Basic display of 12AF with dp on digit 2
    send(16'h12AF, 4'b0100);
    wait_tick();
    for (int j = 1; j <= 27; j++) begin
      @(negedge clk);
      if (j <= 2) begin
        check("basic_blank", {20'h0, seg, digit}, 32'h0);
      end else if ((j - 3) % 8 == 0) begin
        check("basic_digit", {28'h0, digit}, {28'h0, exp_dig[(j - 3) / 8]});
        check("basic_seg", {24'h0, seg}, {24'h0, exp_seg[(j - 3) / 8]});
      end
    end

    // frame_tick period
    begin
      int n;
      bit seen;
      wait_tick();
      n = 0;
      seen = 0;
      for (int c = 0; c < 100 && !seen; c++) begin
        @(negedge clk);
        n++;
        if (frame_tick) seen = 1;
      end
      check("tick_period", n, FRAME);
    end

    // Backpressure: 2222 must wait until 1111 commits
    send(16'h1111, 4'h0);
    in_data = 16'h2222;
    in_dp = 4'h0;
    in_valid = 1'b1;
    @(negedge clk);
    check("bp_ready_low", {31'h0, in_ready}, 32'h0);
    send(16'h2222, 4'h0);
    skip_neg(3);
    check("bp_old_seg", {24'h0, seg}, 32'h06);
    wait_tick();
    skip_neg(3);
    check("bp_new_seg", {24'h0, seg}, 32'h5B);

    // Accept on the frame-boundary cycle is deferred one frame
    send(16'h0005, 4'h0);
    wait_tick();
    wait_tick();
    repeat (31) @(posedge clk);
    #1;
    in_data = 16'h00C3;
    in_dp = 4'h0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("fb_accept_tick", {31'h0, frame_tick}, 32'h1);
    check("fb_accept_taken", {31'h0, in_ready}, 32'h0);
    skip_neg(3);
    check("fb_old_seg", {24'h0, seg}, 32'h6D);
    wait_tick();
    skip_neg(3);
    check("fb_new_seg", {24'h0, seg}, 32'h4F);

    // Random traffic with random gaps
    for (int i = 0; i < 30; i++) begin
      gap = $urandom_range(0, 40);
      repeat (gap) @(posedge clk);
      #1;
      send(16'($urandom), 4'($urandom));
    end

    // Reset during a pending handshake drops the value
    send(16'h4321, 4'hA);
    repeat (2) @(posedge clk);
    #3 rstb = 1'b0;
    #1;
    check("rst2_ready", {31'h0, in_ready}, 32'h1);
    check("rst2_out", {20'h0, seg, digit}, 32'h0);
    @(negedge clk);
    #2 rstb = 1'b1;
    repeat (2 * FRAME + 4) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog got timeout required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
